// File: rtl/fb_port_arbiter_if.sv
// Bundle of the two requester ports and the framebuffer RAM port seen by fb_port_arbiter.
// The arbiter takes the slave view; a requester/RAM-side environment takes the master view.
interface fb_port_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 3
);
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_miss;

  logic              gl_req;
  logic              gl_we;
  logic [ADDR_W-1:0] gl_addr;
  logic [DATA_W-1:0] gl_wdata;
  logic              gl_gnt;
  logic              gl_rvalid;
  logic [DATA_W-1:0] gl_rdata;

  logic [ADDR_W-1:0] ram_address;
  logic              ram_write_enabled;
  logic [DATA_W-1:0] ram_write_data;
  logic [DATA_W-1:0] ram_read_data;

  modport slave (
    input  vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata, ram_read_data,
    output vid_gnt, vid_rvalid, vid_rdata, vid_miss,
    output gl_gnt, gl_rvalid, gl_rdata,
    output ram_address, ram_write_enabled, ram_write_data
  );

  modport master (
    output vid_req, vid_addr, gl_req, gl_we, gl_addr, gl_wdata, ram_read_data,
    input  vid_gnt, vid_rvalid, vid_rdata, vid_miss,
    input  gl_gnt, gl_rvalid, gl_rdata,
    input  ram_address, ram_write_enabled, ram_write_data
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Framebuffer RAM arbiter: video scanout has priority, game logic gets a forced slot
// after MAX_WAIT consecutive denials; read data is steered back by a {valid, owner} tag pipe.
module fb_port_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 3,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  fb_port_arbiter_if.slave   bus
);

  localparam logic [0:0] PRI_VID  = 1'b0;
  localparam logic [0:0] FORCE_GL = 1'b1;

  localparam logic [3:0] WAIT_SAT  = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  logic [0:0]    state;
  logic [3:0]    wait_cnt;
  logic          vid_gnt;
  logic          gl_gnt;
  logic          vid_acc;
  logic          gl_acc;
  logic          gl_held;
  logic          rd_acc;
  logic [RD_LAT:0] vld_p;
  logic [RD_LAT:0] own_gl_p;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == WAIT_SAT) ? v : v + 4'd1;
  endfunction

  always_comb begin
    vid_gnt = 1'b0;
    gl_gnt  = 1'b0;
    case (state)
      FORCE_GL: begin
        gl_gnt  = bus.gl_req;
        vid_gnt = bus.vid_req & ~bus.gl_req;
      end
      default: begin
        vid_gnt = bus.vid_req;
        gl_gnt  = bus.gl_req & ~bus.vid_req;
      end
    endcase
  end

  assign vid_acc = bus.vid_req & vid_gnt;
  assign gl_acc  = bus.gl_req & gl_gnt;
  assign gl_held = bus.gl_req & ~gl_gnt;
  assign rd_acc  = vid_acc | (gl_acc & ~bus.gl_we);

  assign bus.vid_gnt = vid_gnt;
  assign bus.gl_gnt  = gl_gnt;

  // FORCE_GL always grants a pending game request, so it lasts exactly one cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= PRI_VID;
      wait_cnt     <= 4'd0;
      bus.vid_miss <= 1'b0;
    end else begin
      bus.vid_miss <= bus.vid_req & ~vid_gnt;
      case (state)
        FORCE_GL: if (gl_acc || !bus.gl_req) state <= PRI_VID;
        default:  if (gl_held && wait_cnt == WAIT_LAST) state <= FORCE_GL;
      endcase
      if (!bus.gl_req || gl_acc) wait_cnt <= 4'd0;
      else                       wait_cnt <= sat_inc(wait_cnt);
    end
  end

  // p0: RAM port register, winner's address/data presented in the cycle after acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.ram_address       <= '0;
      bus.ram_write_enabled <= 1'b0;
      bus.ram_write_data    <= '0;
    end else begin
      bus.ram_write_enabled <= gl_acc & bus.gl_we;
      if (vid_acc) begin
        bus.ram_address <= bus.vid_addr;
      end else if (gl_acc) begin
        bus.ram_address    <= bus.gl_addr;
        bus.ram_write_data <= bus.gl_wdata;
      end
    end
  end

  // p0..pRD_LAT: read tag pipe, stage RD_LAT lines up with ram_read_data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p    <= '0;
      own_gl_p <= '0;
    end else begin
      vld_p    <= {vld_p[RD_LAT-1:0], rd_acc};
      own_gl_p <= {own_gl_p[RD_LAT-1:0], gl_acc};
    end
  end

  assign bus.vid_rvalid = vld_p[RD_LAT] & ~own_gl_p[RD_LAT];
  assign bus.gl_rvalid  = vld_p[RD_LAT] &  own_gl_p[RD_LAT];
  assign bus.vid_rdata  = bus.ram_read_data;
  assign bus.gl_rdata   = bus.ram_read_data;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: three instances (RD_LAT 1..3) share one stimulus stream,
// each with its own RAM model and in-order response scoreboard; directed checks use RD_LAT=1.
module tb_fb_port_arbiter;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 3;
  localparam int MAX_WAIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              vid_req  = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              gl_req   = 1'b0;
  logic              gl_we    = 1'b0;
  logic [ADDR_W-1:0] gl_addr  = '0;
  logic [DATA_W-1:0] gl_wdata = '0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic              gl;
    logic [DATA_W-1:0] d;
  } rsp_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
    fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(g + 1), .MAX_WAIT(MAX_WAIT)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
    );

    assign bus.vid_req  = vid_req;
    assign bus.vid_addr = vid_addr;
    assign bus.gl_req   = gl_req;
    assign bus.gl_we    = gl_we;
    assign bus.gl_addr  = gl_addr;
    assign bus.gl_wdata = gl_wdata;

    // RAM model: read-first, data appears RD_LAT edges after the address is sampled
    bit [DATA_W-1:0] mem [76800];
    bit [DATA_W-1:0] rd_pipe [g + 1];
    always @(posedge clock) begin
      if (bus.ram_write_enabled) mem[bus.ram_address] <= bus.ram_write_data;
      rd_pipe[0] <= mem[bus.ram_address];
      for (int k = 1; k <= g; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.ram_read_data = rd_pipe[g];

    bit [DATA_W-1:0] shadow [76800];
    rsp_t q[$];
    always @(negedge clock) begin
      rsp_t e;
      if (reset) begin
        q.delete();
      end else begin
        if (bus.vid_rvalid || bus.gl_rvalid) begin
          chk("sb_pending", q.size() != 0, 1);
          chk("sb_both_rvalid", bus.vid_rvalid & bus.gl_rvalid, 0);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("sb_owner", bus.gl_rvalid, e.gl);
            chk("sb_data", e.gl ? bus.gl_rdata : bus.vid_rdata, e.d);
          end
        end
        if (bus.vid_req && bus.vid_gnt) begin
          q.push_back({1'b0, shadow[bus.vid_addr]});
        end else if (bus.gl_req && bus.gl_gnt) begin
          if (bus.gl_we) shadow[bus.gl_addr] = bus.gl_wdata;
          else q.push_back({1'b1, shadow[bus.gl_addr]});
        end
      end
    end
  end

  logic              vid_gnt0, gl_gnt0, vid_rv0, gl_rv0, vid_miss0, ram_we0;
  logic [DATA_W-1:0] vid_rd0, gl_rd0, ram_wd0;
  logic [ADDR_W-1:0] ram_a0;
  logic [3:0]        wait0;
  logic [0:0]        state0;
  logic              vid_rv2, gl_rv2;
  assign vid_gnt0  = g_inst[0].bus.vid_gnt;
  assign gl_gnt0   = g_inst[0].bus.gl_gnt;
  assign vid_rv0   = g_inst[0].bus.vid_rvalid;
  assign gl_rv0    = g_inst[0].bus.gl_rvalid;
  assign vid_miss0 = g_inst[0].bus.vid_miss;
  assign ram_we0   = g_inst[0].bus.ram_write_enabled;
  assign vid_rd0   = g_inst[0].bus.vid_rdata;
  assign gl_rd0    = g_inst[0].bus.gl_rdata;
  assign ram_wd0   = g_inst[0].bus.ram_write_data;
  assign ram_a0    = g_inst[0].bus.ram_address;
  assign wait0     = g_inst[0].dut.wait_cnt;
  assign state0    = g_inst[0].dut.state;
  assign vid_rv2   = g_inst[2].bus.vid_rvalid;
  assign gl_rv2    = g_inst[2].bus.gl_rvalid;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  int e_vg [6] = '{1, 1, 1, 0, 0, 0};
  int e_gg [6] = '{0, 0, 0, 1, 0, 0};
  int e_vr [6] = '{0, 0, 1, 1, 1, 0};
  int e_gr [6] = '{0, 0, 0, 0, 0, 1};
  int e_d  [6] = '{0, 0, 1, 2, 5, 3};
  int wr_a [4] = '{0, 1, 2, 76799};
  int wr_d [4] = '{1, 2, 5, 3};

  initial begin
    logic vacc, gacc;
    int   denied;

    // Reset values
    repeat (2) @(posedge clock);
    at_neg();
    chk("rst_ram_addr", ram_a0, 0);
    chk("rst_ram_we", ram_we0, 0);
    chk("rst_ram_wdata", ram_wd0, 0);
    chk("rst_vid_rvalid", vid_rv0, 0);
    chk("rst_gl_rvalid", gl_rv0, 0);
    chk("rst_vid_miss", vid_miss0, 0);
    chk("rst_wait_cnt", wait0, 0);
    chk("rst_state", state0, 0);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // T1: game write then read of address 100
    gl_req = 1'b1; gl_we = 1'b1; gl_addr = 19'd100; gl_wdata = 3'b100;
    at_neg();
    chk("t1_gl_gnt", gl_gnt0, 1);
    chk("t1_vid_gnt", vid_gnt0, 0);
    next_cycle();
    gl_we = 1'b0;
    at_neg();
    chk("t1_ram_we", ram_we0, 1);
    chk("t1_ram_addr", ram_a0, 100);
    chk("t1_ram_wdata", ram_wd0, 3'b100);
    chk("t1_rd_gnt", gl_gnt0, 1);
    next_cycle();
    gl_req = 1'b0;
    at_neg();
    chk("t1_we_one_cycle", ram_we0, 0);
    chk("t1_rvalid_early", gl_rv0, 0);
    next_cycle();
    at_neg();
    chk("t1_gl_rvalid", gl_rv0, 1);
    chk("t1_gl_rdata", gl_rd0, 3'b100);
    chk("t1_vid_rvalid", vid_rv0, 0);
    next_cycle();
    at_neg();
    chk("t1_rvalid_once", gl_rv0, 0);
    next_cycle();

    // T2: video held continuously, game read forced through after MAX_WAIT denials
    vid_req = 1'b1; vid_addr = 19'd5; gl_req = 1'b1; gl_we = 1'b0; gl_addr = 19'd7;
    for (int c = 0; c < 6; c++) begin
      at_neg();
      chk($sformatf("t2_gl_gnt_c%0d", c), gl_gnt0, (c == 4) ? 1 : 0);
      chk($sformatf("t2_vid_gnt_c%0d", c), vid_gnt0, (c == 4) ? 0 : 1);
      chk($sformatf("t2_vid_miss_c%0d", c), vid_miss0, (c == 5) ? 1 : 0);
      if (c == 3) chk("t2_wait_c3", wait0, 3);
      if (c == 4) begin
        chk("t2_wait_sat", wait0, 4);
        chk("t2_state_force", state0, 1);
      end
      if (c == 5) chk("t2_state_back", state0, 0);
      next_cycle();
      if (c == 4) gl_req = 1'b0;
    end
    vid_req = 1'b0;
    repeat (3) next_cycle();

    // T3: preload, then simultaneous video/game reads
    for (int i = 0; i < 4; i++) begin
      gl_req = 1'b1; gl_we = 1'b1; gl_addr = 19'(wr_a[i]); gl_wdata = 3'(wr_d[i]);
      at_neg();
      chk("t3_wr_gnt", gl_gnt0, 1);
      next_cycle();
    end
    gl_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vid_req = (i < 3); vid_addr = 19'(i);
      gl_req = (i < 4); gl_we = 1'b0; gl_addr = 19'd76799;
      at_neg();
      chk($sformatf("t3_vid_gnt_c%0d", i), vid_gnt0, e_vg[i]);
      chk($sformatf("t3_gl_gnt_c%0d", i), gl_gnt0, e_gg[i]);
      chk($sformatf("t3_vid_rv_c%0d", i), vid_rv0, e_vr[i]);
      chk($sformatf("t3_gl_rv_c%0d", i), gl_rv0, e_gr[i]);
      if (e_vr[i] != 0) chk($sformatf("t3_vid_rd_c%0d", i), vid_rd0, e_d[i]);
      if (e_gr[i] != 0) chk($sformatf("t3_gl_rd_c%0d", i), gl_rd0, e_d[i]);
      next_cycle();
    end
    repeat (2) next_cycle();

    // T4: game write withdrawn before the forced slot
    for (int c = 0; c < 4; c++) begin
      vid_req = (c < 3); vid_addr = 19'd9;
      gl_req = (c < 2); gl_we = 1'b1; gl_addr = 19'd50; gl_wdata = 3'd7;
      at_neg();
      chk($sformatf("t4_gl_gnt_c%0d", c), gl_gnt0, 0);
      chk($sformatf("t4_ram_we_c%0d", c), ram_we0, 0);
      if (c == 2) chk("t4_wait_c2", wait0, 2);
      if (c == 3) begin
        chk("t4_wait_clr", wait0, 0);
        chk("t4_state", state0, 0);
      end
      next_cycle();
    end
    gl_req = 1'b1; gl_we = 1'b0; gl_addr = 19'd50;
    next_cycle();
    gl_req = 1'b0;
    next_cycle();
    at_neg();
    chk("t4_readback_rv", gl_rv0, 1);
    chk("t4_readback_data", gl_rd0, 0);
    next_cycle();

    // T5: reset with two reads in flight
    vid_req = 1'b1; vid_addr = 19'd1;
    next_cycle();
    vid_req = 1'b0; gl_req = 1'b1; gl_we = 1'b0; gl_addr = 19'd100;
    next_cycle();
    gl_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_vid_rvalid", vid_rv0, 0);
    chk("t5_gl_rvalid", gl_rv0, 0);
    chk("t5_ram_addr", ram_a0, 0);
    chk("t5_ram_we", ram_we0, 0);
    chk("t5_ram_wdata", ram_wd0, 0);
    chk("t5_vid_miss", vid_miss0, 0);
    chk("t5_grants", vid_gnt0 | gl_gnt0, 0);
    chk("t5_rvalid_lat3", vid_rv2 | gl_rv2, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      at_neg();
      chk($sformatf("t5_no_rv_lat1_c%0d", c), vid_rv0 | gl_rv0, 0);
      chk($sformatf("t5_no_rv_lat3_c%0d", c), vid_rv2 | gl_rv2, 0);
      next_cycle();
    end
    gl_req = 1'b1; gl_we = 1'b1; gl_addr = 19'd200; gl_wdata = 3'd6;
    at_neg();
    chk("t5_post_gnt", gl_gnt0, 1);
    next_cycle();
    gl_req = 1'b0;
    at_neg();
    chk("t5_post_we", ram_we0, 1);
    chk("t5_post_addr", ram_a0, 200);
    next_cycle();

    // T6: continuous mixed traffic, requests held until granted
    denied = 0;
    for (int n = 0; n < 400; n++) begin
      at_neg();
      vacc = vid_req & vid_gnt0;
      gacc = gl_req & gl_gnt0;
      chk("t6_one_gnt", vid_gnt0 & gl_gnt0, 0);
      chk("t6_gnt_needs_req", (vid_gnt0 & ~vid_req) | (gl_gnt0 & ~gl_req), 0);
      denied = (gl_req && !gacc) ? denied + 1 : 0;
      chk("t6_wait_bound", denied <= MAX_WAIT, 1);
      next_cycle();
      if (!vid_req || vacc) begin
        vid_req  = ($urandom_range(0, 3) != 0);
        vid_addr = 19'($urandom_range(0, 15));
      end
      if (!gl_req || gacc) begin
        gl_req   = 1'($urandom_range(0, 1));
        gl_we    = 1'($urandom_range(0, 1));
        gl_addr  = 19'($urandom_range(0, 15));
        gl_wdata = 3'($urandom_range(0, 7));
      end
    end
    vid_req = 1'b0;
    gl_req  = 1'b0;
    repeat (8) next_cycle();
    chk("t6_drain_lat1", g_inst[0].q.size(), 0);
    chk("t6_drain_lat2", g_inst[1].q.size(), 0);
    chk("t6_drain_lat3", g_inst[2].q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
